// File: rtl/cache_pkg.sv
// Shared types and default widths for the direct-mapped write-through cache.
package cache_pkg;

  // Default geometry: data word width, index width, CPU word-address width.
  localparam int DEF_ANCHO = 32;
  localparam int DEF_PROF  = 6;
  localparam int DEF_DIR   = 32;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    WTHRU  = 2'd3
  } cache_state_t;

endpackage

// File: rtl/cache_tags.sv
// Tag and valid-bit storage for the direct-mapped cache.
// Combinational read, registered write, synchronous clear of all valid bits.
// Tags themselves are never cleared; a cleared valid bit makes them irrelevant.
module cache_tags
  import cache_pkg::*;
#(
  parameter int PROF = DEF_PROF,
  parameter int TAGW = DEF_DIR - DEF_PROF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PROF-1:0] rd_idx,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  input  logic            wr_en,
  input  logic [PROF-1:0] wr_idx,
  input  logic [TAGW-1:0] wr_tag
);

  localparam int LINES = 2 ** PROF;

  logic [LINES-1:0] valid_r;
  logic [TAGW-1:0]  tag_r [LINES];

  // Valid bits: cleared by reset, set when a line is allocated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag storage: written on allocation only, deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache
// controller. The data array lives outside this block and is driven through
// the arr_* ports. Optional hit/miss statistics are built only when the
// macro CACHE_STATS_EN is defined; otherwise the counter ports read as zero.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ANCHO = DEF_ANCHO,
  parameter int PROF  = DEF_PROF,
  parameter int DIR   = DEF_DIR
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [DIR-1:0]   cpu_addr_i,
  input  logic [ANCHO-1:0] cpu_wdata_i,
  output logic [ANCHO-1:0] cpu_rdata_o,
  output logic             cpu_ready_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [DIR-1:0]   mem_addr_o,
  output logic [ANCHO-1:0] mem_wdata_o,
  input  logic [ANCHO-1:0] mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             arr_wren_o,
  output logic [PROF-1:0]  arr_wraddr_o,
  output logic [ANCHO-1:0] arr_wrdata_o,
  output logic [PROF-1:0]  arr_rdaddr_o,
  input  logic [ANCHO-1:0] arr_rddata_i,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
);

  localparam int TAGW = DIR - PROF;

  cache_state_t     state_r;
  cache_state_t     state_nx_s;
  logic [DIR-1:0]   addr_r;
  logic [ANCHO-1:0] wdata_r;
  logic             we_r;

  logic [PROF-1:0]  idx_s;
  logic [TAGW-1:0]  tag_s;
  logic             line_valid_s;
  logic [TAGW-1:0]  line_tag_s;
  logic             hit_s;
  logic             tag_wr_s;

  assign idx_s = addr_r[PROF-1:0];
  assign tag_s = addr_r[DIR-1:PROF];
  assign hit_s = line_valid_s && (line_tag_s == tag_s);

  cache_tags #(
    .PROF (PROF),
    .TAGW (TAGW)
  ) u_tags (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (idx_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .wr_en    (tag_wr_s),
    .wr_idx   (idx_s),
    .wr_tag   (tag_s)
  );

  // State register; reset drops any in-flight transaction back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture the CPU request once in IDLE; held for the whole transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r  <= {DIR{1'b0}};
      wdata_r <= {ANCHO{1'b0}};
      we_r    <= 1'b0;
    end else if ((state_r == IDLE) && cpu_req_i) begin
      addr_r  <= cpu_addr_i;
      wdata_r <= cpu_wdata_i;
      we_r    <= cpu_we_i;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
    end
  end

  // Next-state and output decode; every output is zero unless asserted.
  always_comb begin
    state_nx_s   = state_r;
    cpu_ready_o  = 1'b0;
    cpu_rdata_o  = {ANCHO{1'b0}};
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = {DIR{1'b0}};
    mem_wdata_o  = {ANCHO{1'b0}};
    arr_wren_o   = 1'b0;
    arr_wraddr_o = {PROF{1'b0}};
    arr_wrdata_o = {ANCHO{1'b0}};
    arr_rdaddr_o = {PROF{1'b0}};
    tag_wr_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (cpu_req_i) begin
          state_nx_s = LOOKUP;
        end else begin
          state_nx_s = IDLE;
        end
      end

      LOOKUP: begin
        arr_rdaddr_o = idx_s;
        if (we_r) begin
          // Writes always go through to memory; update the array only on a hit.
          state_nx_s = WTHRU;
          if (hit_s) begin
            arr_wren_o   = 1'b1;
            arr_wraddr_o = idx_s;
            arr_wrdata_o = wdata_r;
          end else begin
            arr_wren_o   = 1'b0;
          end
        end else if (hit_s) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = arr_rddata_i;
          state_nx_s  = IDLE;
        end else begin
          state_nx_s  = REFILL;
        end
      end

      REFILL: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b0;
        mem_addr_o = addr_r;
        if (mem_ack_i) begin
          // Fill the line (replacing any other tag) and forward the word.
          arr_wren_o   = 1'b1;
          arr_wraddr_o = idx_s;
          arr_wrdata_o = mem_rdata_i;
          tag_wr_s     = 1'b1;
          cpu_ready_o  = 1'b1;
          cpu_rdata_o  = mem_rdata_i;
          state_nx_s   = IDLE;
        end else begin
          state_nx_s   = REFILL;
        end
      end

      WTHRU: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_r;
        mem_wdata_o = wdata_r;
        if (mem_ack_i) begin
          cpu_ready_o = 1'b1;
          state_nx_s  = IDLE;
        end else begin
          state_nx_s  = WTHRU;
        end
      end

      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Count each lookup outcome once; counters wrap naturally at 2**32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else if (state_r == LOOKUP) begin
      if (hit_s) begin
        hit_cnt_r  <= hit_cnt_r + 32'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end else begin
      hit_cnt_r  <= hit_cnt_r;
      miss_cnt_r <= miss_cnt_r;
    end
  end

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural backing memory, external
// data array, and a scoreboard queue of expected read data.
module tb_cache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_ready_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        arr_wren_o;
  logic [5:0]  arr_wraddr_o, arr_rdaddr_o;
  logic [31:0] arr_wrdata_o, arr_rddata_i;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  logic [31:0] arr_mem [64];
  logic [31:0] mem_mdl [logic [31:0]];
  logic [31:0] sb_q [$];

  int checks   = 0;
  int failures = 0;

  cache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .arr_wren_o   (arr_wren_o),
    .arr_wraddr_o (arr_wraddr_o),
    .arr_wrdata_o (arr_wrdata_o),
    .arr_rdaddr_o (arr_rdaddr_o),
    .arr_rddata_i (arr_rddata_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // External data array: registered write, combinational read.
  always @(posedge clk_i) begin
    if (arr_wren_o) arr_mem[arr_wraddr_o] <= arr_wrdata_o;
  end
  assign arr_rddata_i = arr_mem[arr_rdaddr_o];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stats_exp(input logic [31:0] n);
`ifdef CACHE_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // One CPU access; the bench memory acks after ack_dly cycles of mem_req_o.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_dly, output int lat, output int mem_cyc, output int arr_wr);
    logic [31:0] exp;
    bit done;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    if (!we) sb_q.push_back(mem_mdl[addr]);
    lat = 0; mem_cyc = 0; arr_wr = 0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk_i); #1;
      lat++;
      if (mem_req_o) begin
        mem_cyc++;
        check_eq("mem_addr", mem_addr_o, addr);
        check_eq("mem_we", 32'(mem_we_o), 32'(we));
        if (we) check_eq("mem_wdata", mem_wdata_o, wdata);
        if (mem_cyc >= ack_dly) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = we ? 32'h0 : mem_mdl[addr];
          if (we) mem_mdl[addr] = wdata;
        end
      end
      #1;
      if (arr_wren_o) arr_wr++;
      if (cpu_ready_o) begin
        done = 1'b1;
        if (!we) begin
          exp = sb_q.pop_front();
          check_eq("cpu_rdata", cpu_rdata_o, exp);
        end
      end
    end
    if (!done) check_eq("ready_timeout", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    check_eq("mem_req_drop", 32'(mem_req_o), 32'd0);
    check_eq("ready_pulse", 32'(cpu_ready_o), 32'd0);
  endtask

  int  lat, mc, aw, rdy_seen;
  bit  in_refill;

  initial begin
    for (int i = 0; i < 64; i++) arr_mem[i] = 32'h0;
    mem_mdl[32'h40]  = 32'hDEADBEEF;
    mem_mdl[32'h80]  = 32'hCAFEF00D;
    mem_mdl[32'h1C3] = 32'h0BADC0DE;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_eq("rst_ready", 32'(cpu_ready_o), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("rst_arr_wren", 32'(arr_wren_o), 32'd0);
    check_eq("rst_rdata", cpu_rdata_o, 32'd0);
    check_eq("rst_hits", hit_cnt_o, 32'd0);
    check_eq("rst_misses", miss_cnt_o, 32'd0);

    // Cold read miss: refill index 0.
    cpu_access(1'b0, 32'h40, 32'h0, 1, lat, mc, aw);
    check_eq("miss1_lat", lat, 2);
    check_eq("miss1_memcyc", mc, 1);
    check_eq("miss1_arrwr", aw, 1);
    check_eq("miss1_arr0", arr_mem[0], 32'hDEADBEEF);
    check_eq("miss1_misses", miss_cnt_o, stats_exp(32'd1));

    // Read hit: ready one edge after the request cycle, no memory traffic.
    cpu_access(1'b0, 32'h40, 32'h0, 1, lat, mc, aw);
    check_eq("hit1_lat", lat, 1);
    check_eq("hit1_memcyc", mc, 0);
    check_eq("hit1_arrwr", aw, 0);
    check_eq("hit1_hits", hit_cnt_o, stats_exp(32'd1));

    // Write hit with a 3-cycle memory ack.
    cpu_access(1'b1, 32'h40, 32'h12345678, 3, lat, mc, aw);
    check_eq("wr_hit_memcyc", mc, 3);
    check_eq("wr_hit_arrwr", aw, 1);
    check_eq("wr_hit_arr0", arr_mem[0], 32'h12345678);
    check_eq("wr_hit_hits", hit_cnt_o, stats_exp(32'd2));

    cpu_access(1'b0, 32'h40, 32'h0, 1, lat, mc, aw);
    check_eq("hit2_lat", lat, 1);
    check_eq("hit2_memcyc", mc, 0);
    check_eq("hit2_hits", hit_cnt_o, stats_exp(32'd3));

    // Conflict: same index, new tag replaces the line.
    cpu_access(1'b0, 32'h80, 32'h0, 2, lat, mc, aw);
    check_eq("conf_memcyc", mc, 2);
    check_eq("conf_arr0", arr_mem[0], 32'hCAFEF00D);
    cpu_access(1'b0, 32'h40, 32'h0, 1, lat, mc, aw);
    check_eq("evict_lat", lat, 2);
    check_eq("evict_memcyc", mc, 1);
    check_eq("evict_misses", miss_cnt_o, stats_exp(32'd3));

    // Write miss: no allocation, array untouched.
    cpu_access(1'b1, 32'h1C3, 32'hA5A5A5A5, 1, lat, mc, aw);
    check_eq("wmiss_memcyc", mc, 1);
    check_eq("wmiss_arrwr", aw, 0);
    check_eq("wmiss_arr3", arr_mem[3], 32'h0);
    cpu_access(1'b0, 32'h1C3, 32'h0, 1, lat, mc, aw);
    check_eq("wmiss_rd_lat", lat, 2);
    check_eq("wmiss_rd_memcyc", mc, 1);
    check_eq("wmiss_rd_misses", miss_cnt_o, stats_exp(32'd5));

    // Reset during REFILL, late ack must be ignored.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    in_refill = 1'b0; rdy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (cpu_ready_o) rdy_seen++;
      if (mem_req_o) begin
        in_refill = 1'b1;
        break;
      end
    end
    check_eq("rr_reached_refill", 32'(in_refill), 32'd1);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_eq("rr_mem_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    #1;
    if (cpu_ready_o) rdy_seen++;
    check_eq("rr_arr_wren", 32'(arr_wren_o), 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    if (cpu_ready_o) rdy_seen++;
    check_eq("rr_no_ready", rdy_seen, 0);
    check_eq("rr_hits", hit_cnt_o, 32'd0);
    check_eq("rr_misses", miss_cnt_o, 32'd0);

    // Valid bits were cleared: 0x40 misses again.
    cpu_access(1'b0, 32'h40, 32'h0, 1, lat, mc, aw);
    check_eq("post_rst_lat", lat, 2);
    check_eq("post_rst_memcyc", mc, 1);
    check_eq("post_rst_misses", miss_cnt_o, stats_exp(32'd1));
    check_eq("post_rst_hits", hit_cnt_o, 32'd0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
